// File: rtl/detect_pkg.sv
// detect_array_csr shared definitions: register map and CONTROL layout.
// Imported by the CSR top and the per-channel debounce.
package detect_pkg;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] ADDR_CONTROL  = 5'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 5'd1;
  localparam logic [ADDR_W-1:0] ADDR_EDGE     = 5'd2;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 5'd3;
  localparam logic [ADDR_W-1:0] ADDR_THR_BASE = 5'd4;

  localparam int EN_BIT  = 0;
  localparam int DBC_LSB = 16;
  localparam int DBC_MSB = 31;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/detect_debounce.sv
// One detect channel: synchroniser, disagreement counter, debounced
// level and a same-edge rising pulse for the sticky flag logic.
module detect_debounce
  import detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             en,
  input  logic [CNT_W-1:0] dbc,
  input  logic             din,
  output logic             d,
  output logic             rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;
  logic                   hit;

  assign s    = sync[SYNC_STAGES-1];
  // >= keeps a lowered DBC effective even if cnt is already past it
  assign hit  = en && (s != d) && (cnt >= dbc);
  assign rise = hit && !d;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sync <= '0;
      cnt  <= '0;
      d    <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      if (!en || (s == d)) begin
        cnt <= '0;
      end else if (hit) begin
        d   <= ~d;
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/detect_array_csr.sv
// Multi-channel detect/threshold CSR block on the lightweight Avalon-MM
// bus: debounced levels, sticky edges, masked irq and per-channel thresholds.
module detect_array_csr
  import detect_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          THR_W       = 32,
  parameter logic [31:0] THR_RESET   = 32'h700,
  parameter logic [15:0] DBC_RESET   = 16'd100,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    s_cs,
  input  logic [4:0]              s_address,
  input  logic                    s_read,
  output logic [31:0]             s_readdata,
  input  logic                    s_write,
  input  logic [31:0]             s_writedata,
  input  logic [NUM_CH-1:0]       iDetect,
  output logic [NUM_CH*THR_W-1:0] oThreshold,
  output logic                    oIrq
);

  localparam logic [THR_W-1:0] THR_INIT = THR_RESET[THR_W-1:0];

  logic              en;
  logic [CNT_W-1:0]  dbc;
  logic [NUM_CH-1:0] lvl;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] edge_q;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] clr;
  logic [THR_W-1:0]  thr [NUM_CH];
  logic [31:0]       rd_mux;
  logic              wr;
  logic              rd;

  assign wr = s_cs & s_write;
  assign rd = s_cs & s_read;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    detect_debounce #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_dbc (
      .iClk (iClk),
      .iRst (iRst),
      .en   (en),
      .dbc  (dbc),
      .din  (iDetect[i]),
      .d    (lvl[i]),
      .rise (rise[i])
    );
    assign oThreshold[i*THR_W +: THR_W] = thr[i];
  end

  always_comb begin
    clr = '0;
    if (wr && (s_address == ADDR_EDGE)) begin
      clr = s_writedata[NUM_CH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (s_address == ADDR_CONTROL): begin
        rd_mux[EN_BIT]          = en;
        rd_mux[DBC_MSB:DBC_LSB] = dbc;
      end
      (s_address == ADDR_STATUS):
        rd_mux[NUM_CH-1:0] = lvl;
      (s_address == ADDR_EDGE):
        rd_mux[NUM_CH-1:0] = edge_q;
      (s_address == ADDR_IRQ_MASK):
        rd_mux[NUM_CH-1:0] = mask;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (s_address == ADDR_THR_BASE + 5'(i)) begin
            rd_mux[THR_W-1:0] = thr[i];
          end
        end
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      en         <= 1'b1;
      dbc        <= DBC_RESET;
      mask       <= '0;
      edge_q     <= '0;
      oIrq       <= 1'b0;
      s_readdata <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        thr[i] <= THR_INIT;
      end
    end else begin
      s_readdata <= rd ? rd_mux : 32'h0;
      oIrq       <= |(edge_q & mask);
      // a new rise beats a same-cycle W1C
      edge_q     <= (edge_q & ~clr) | rise;
      if (wr && (s_address == ADDR_CONTROL)) begin
        en  <= s_writedata[EN_BIT];
        dbc <= s_writedata[DBC_MSB:DBC_LSB];
      end
      if (wr && (s_address == ADDR_IRQ_MASK)) begin
        mask <= s_writedata[NUM_CH-1:0];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && (s_address == ADDR_THR_BASE + 5'(i))) begin
          thr[i] <= s_writedata[THR_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_detect_array_csr.sv
// Bench for detect_array_csr: cycle model of the register map and
// debounce rules, per-cycle output compare, directed and random stimulus.
module tb_detect_array_csr;

  localparam int NUM_CH = 4;
  localparam int THR_W  = 32;
  localparam int SYNC   = 2;

  logic                    iClk = 1'b0;
  logic                    iRst = 1'b1;
  logic                    s_cs;
  logic [4:0]              s_address;
  logic                    s_read;
  logic [31:0]             s_readdata;
  logic                    s_write;
  logic [31:0]             s_writedata;
  logic [NUM_CH-1:0]       iDetect;
  logic [NUM_CH*THR_W-1:0] oThreshold;
  logic                    oIrq;

  int n_vec = 0;
  int n_bad = 0;

  always #5 iClk = ~iClk;

  detect_array_csr #(
    .NUM_CH      (NUM_CH),
    .THR_W       (THR_W),
    .THR_RESET   (32'h700),
    .DBC_RESET   (16'd100),
    .SYNC_STAGES (SYNC)
  ) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .s_cs        (s_cs),
    .s_address   (s_address),
    .s_read      (s_read),
    .s_readdata  (s_readdata),
    .s_write     (s_write),
    .s_writedata (s_writedata),
    .iDetect     (iDetect),
    .oThreshold  (oThreshold),
    .oIrq        (oIrq)
  );

  // reference model state
  logic              m_en;
  logic [15:0]       m_dbc;
  logic [NUM_CH-1:0] m_lvl;
  logic [NUM_CH-1:0] m_edge;
  logic [NUM_CH-1:0] m_mask;
  logic [31:0]       m_thr [NUM_CH];
  logic              m_irq;
  logic [31:0]       m_rdata;
  int                m_run [NUM_CH];
  logic [NUM_CH-1:0] m_hist [8];
  int                m_k;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return {m_dbc, 15'b0, m_en};
    if (ai == 1) return 32'(m_lvl);
    if (ai == 2) return 32'(m_edge);
    if (ai == 3) return 32'(m_mask);
    if (ai >= 4 && ai < 4 + NUM_CH) return m_thr[ai-4];
    return 32'h0;
  endfunction

  always @(posedge iClk or posedge iRst) begin : mdl
    logic [NUM_CH-1:0] s_cur;
    logic [NUM_CH-1:0] rise_v;
    logic [NUM_CH-1:0] lvl_n;
    logic [NUM_CH-1:0] clr;
    int                run_n [NUM_CH];
    if (iRst) begin
      m_en    <= 1'b1;
      m_dbc   <= 16'd100;
      m_lvl   <= '0;
      m_edge  <= '0;
      m_mask  <= '0;
      m_irq   <= 1'b0;
      m_rdata <= '0;
      m_k     <= 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_thr[i] <= 32'h700;
        m_run[i] <= 0;
      end
      for (int j = 0; j < 8; j++) m_hist[j] <= '0;
    end else begin
      // input seen by the debounce is the one applied SYNC edges ago
      s_cur  = m_hist[(m_k + 8 - SYNC) % 8];
      rise_v = '0;
      lvl_n  = m_lvl;
      for (int i = 0; i < NUM_CH; i++) begin
        run_n[i] = m_run[i];
        if (!m_en || s_cur[i] == m_lvl[i]) begin
          run_n[i] = 0;
        end else if (m_run[i] >= int'(m_dbc)) begin
          lvl_n[i]  = ~m_lvl[i];
          run_n[i]  = 0;
          rise_v[i] = lvl_n[i];
        end else if (m_run[i] < 65535) begin
          run_n[i] = m_run[i] + 1;
        end
      end
      m_hist[m_k] <= iDetect;
      m_k         <= (m_k + 1) % 8;
      m_rdata     <= (s_cs && s_read) ? m_read(s_address) : 32'h0;
      m_irq       <= |(m_edge & m_mask);
      clr = '0;
      if (s_cs && s_write && s_address == 5'd2) clr = s_writedata[NUM_CH-1:0];
      m_edge <= (m_edge & ~clr) | rise_v;
      m_lvl  <= lvl_n;
      for (int i = 0; i < NUM_CH; i++) m_run[i] <= run_n[i];
      if (s_cs && s_write) begin
        if (s_address == 5'd0) begin
          m_en  <= s_writedata[0];
          m_dbc <= s_writedata[31:16];
        end
        if (s_address == 5'd3) m_mask <= s_writedata[NUM_CH-1:0];
        for (int i = 0; i < NUM_CH; i++)
          if (int'(s_address) == 4 + i) m_thr[i] <= s_writedata;
      end
    end
  end

  always @(negedge iClk) begin
    chk("rdata", s_readdata, m_rdata);
    chk("irq", 32'(oIrq), 32'(m_irq));
    for (int i = 0; i < NUM_CH; i++)
      chk("thr_out", oThreshold[i*THR_W +: THR_W], m_thr[i]);
  end

  task automatic idle();
    s_cs = 0; s_read = 0; s_write = 0;
    s_address = '0; s_writedata = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    s_cs = 1; s_write = 1; s_read = 0; s_address = a; s_writedata = d;
    @(negedge iClk);
    idle();
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    s_cs = 1; s_read = 1; s_write = 0; s_address = a;
    @(negedge iClk);
    idle();
    d = s_readdata;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge iClk);
  endtask

  initial begin
    logic [31:0] v;
    idle();
    iDetect = '0;
    cyc(3);
    iRst = 0;
    chk("rst_irq", 32'(oIrq), 32'h0);
    chk("rst_thr3", oThreshold[3*THR_W +: THR_W], 32'h700);
    rd(5'd4, v);  chk("rst_rd_thr0", v, 32'h700);
    rd(5'd0, v);  chk("rst_rd_ctrl", v, 32'h0064_0001);

    wr(5'd6, 32'h1234);
    chk("thr2_wr", oThreshold[2*THR_W +: THR_W], 32'h1234);
    chk("thr1_keep", oThreshold[1*THR_W +: THR_W], 32'h700);

    wr(5'd3, 32'h1);
    wr(5'd0, 32'h0003_0001);
    iDetect[0] = 1; cyc(3); iDetect[0] = 0; cyc(10);
    rd(5'd1, v);  chk("glitch_status", v, 32'h0);

    // step: STATUS flips on edge 6 after the step
    iDetect[0] = 1; cyc(5);
    rd(5'd1, v);  chk("step_edge6_old", v, 32'h0);
    chk("irq_lag", 32'(oIrq), 32'h0);
    rd(5'd1, v);  chk("step_edge7", v, 32'h1);
    chk("irq_set", 32'(oIrq), 32'h1);
    rd(5'd2, v);  chk("edge_set", v, 32'h1);
    wr(5'd2, 32'h1);
    chk("irq_hold", 32'(oIrq), 32'h1);
    cyc(1);
    chk("irq_clr", 32'(oIrq), 32'h0);

    iDetect[0] = 0; cyc(12);
    iDetect[0] = 1; cyc(5);
    wr(5'd2, 32'h1);
    rd(5'd2, v);  chk("set_beats_clr", v, 32'h1);
    wr(5'd2, 32'h1);
    rd(5'd2, v);  chk("edge_cleared", v, 32'h0);

    wr(5'd0, 32'h0003_0000);
    iDetect[1] = 1; cyc(20);
    rd(5'd1, v);  chk("en0_status", v, 32'h1);
    rd(5'd2, v);  chk("en0_edge", v, 32'h0);
    wr(5'd0, 32'h0003_0001);
    cyc(3);
    rd(5'd1, v);  chk("en1_restart_old", v, 32'h1);
    rd(5'd1, v);  chk("en1_restart_new", v, 32'h3);

    rd(5'd31, v); chk("rd_unmapped", v, 32'h0);
    s_cs = 1; s_read = 1; s_write = 1; s_address = 5'd3; s_writedata = 32'h5;
    cyc(1);
    idle();
    chk("rw_same_old", s_readdata, 32'h1);
    rd(5'd3, v);  chk("rw_same_new", v, 32'h5);

    for (int n = 0; n < 3000; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      s_cs   = ($urandom_range(0, 7) != 0);
      s_read = (op < 5);
      s_write = (op >= 4 && op < 8);
      s_address = ($urandom_range(0, 15) == 0) ? 5'(31) : 5'($urandom_range(0, 8));
      s_writedata = $urandom;
      if (s_address == 5'd0)
        s_writedata = {16'($urandom_range(0, 5)), 15'b0,
                       1'($urandom_range(0, 7) != 0)};
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 5) == 0) iDetect[c] = ~iDetect[c];
      cyc(1);
    end
    idle();

    wr(5'd4, 32'hA5A5);
    wr(5'd0, 32'h0005_0001);
    iDetect = '1;
    cyc(4);
    s_cs = 1; s_read = 1; s_address = 5'd4;
    @(posedge iClk);
    #2 iRst = 1;
    #1;
    chk("midrst_rdata", s_readdata, 32'h0);
    chk("midrst_irq", 32'(oIrq), 32'h0);
    chk("midrst_thr0", oThreshold[0 +: THR_W], 32'h700);
    @(negedge iClk);
    idle();
    cyc(2);
    iRst = 0;
    rd(5'd1, v);  chk("postrst_status", v, 32'h0);
    rd(5'd0, v);  chk("postrst_ctrl", v, 32'h0064_0001);
    rd(5'd2, v);  chk("postrst_edge", v, 32'h0);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
